// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first over WIDTH cycles.
// Start/busy/done handshake with a registered sum, carry-out and signed-overflow result.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CntMsb  = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q, c_msb_q;
    logic             s, c_next;

    assign s      = a_q[0] ^ b_q[0] ^ c_q;
    assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            c_msb_q  <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is x + ~y + 1: invert y and seed the carry with 1.
                        a_q     <= x;
                        b_q     <= sub ? ~y : y;
                        c_q     <= sub;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    c_q   <= c_next;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    acc_q <= {s, acc_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntMsb) begin
                        c_msb_q <= c_next;
                    end
                    if (cnt_q == CntLast) begin
                        sum      <= {s, acc_q[WIDTH-1:1]};
                        carry    <= c_next;
                        overflow <= c_msb_q ^ c_next;
                        cnt_q    <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=13, plus a short randomised sweep
// checked against an arithmetic reference.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  x8 = '0, y8 = '0;
    logic [7:0]  sum8;
    logic        carry8, ovf8, busy8, done8;
    logic        start13 = 1'b0, sub13 = 1'b0;
    logic [12:0] x13 = '0, y13 = '0;
    logic [12:0] sum13;
    logic        carry13, ovf13, busy13, done13;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .x(x8), .y(y8),
        .sum(sum8), .carry(carry8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .sub(sub13), .x(x13), .y(y13),
        .sum(sum13), .carry(carry13), .overflow(ovf13), .busy(busy13), .done(done13)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts from the current negedge (1) until done is seen; lat is edges after the accept edge.
    task automatic wait_done(input bit wide, output int lat, output int bcyc);
        lat  = 0;
        bcyc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (wide ? busy13 : busy8) bcyc++;
            if (wide ? done13 : done8) begin
                lat = i - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input bit wide, input logic [12:0] xa, input logic [12:0] ya,
                          input logic sb, output int lat, output int bcyc);
        @(negedge clk);
        if (wide) begin
            x13 = xa; y13 = ya; sub13 = sb; start13 = 1'b1;
        end else begin
            x8 = xa[7:0]; y8 = ya[7:0]; sub8 = sb; start8 = 1'b1;
        end
        @(negedge clk);
        start8  = 1'b0;
        start13 = 1'b0;
        wait_done(wide, lat, bcyc);
    endtask

    // Returns {overflow, carry, sum} for a w-bit operation.
    function automatic logic [31:0] model(input int w, input logic [31:0] xa,
                                          input logic [31:0] ya, input logic sb);
        logic [31:0] mask, a, b, full, s;
        logic        ov;
        mask = (32'd1 << w) - 1;
        a    = xa & mask;
        b    = (sb ? ~ya : ya) & mask;
        full = a + b + {31'd0, sb};
        s    = full & mask;
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return s | ({31'd0, full[w]} << w) | ({31'd0, ov} << (w + 1));
    endfunction

    task automatic check_result(input bit wide, input string tag, input logic [31:0] exp,
                                input int lat);
        int w;
        w = wide ? 13 : 8;
        if (wide) chk({tag, ".sum"}, {19'd0, sum13}, exp & 32'h1FFF);
        else      chk({tag, ".sum"}, {24'd0, sum8}, exp & 32'hFF);
        chk({tag, ".carry"}, {31'd0, wide ? carry13 : carry8}, {31'd0, exp[w]});
        chk({tag, ".ovf"}, {31'd0, wide ? ovf13 : ovf8}, {31'd0, exp[w+1]});
        chk({tag, ".lat"}, lat, w);
    endtask

    initial begin
        int lat, bcyc;
        bit seen;
        logic [31:0] rx, ry;
        logic        rs;

        // Reset state
        #3;
        chk("rst.sum", {24'd0, sum8}, 32'h0);
        chk("rst.flags", {28'd0, carry8, ovf8, busy8, done8}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: 5A + 3C
        run_op(1'b0, 13'h5A, 13'h3C, 1'b0, lat, bcyc);
        chk("t1.sum", {24'd0, sum8}, 32'h96);
        chk("t1.carry", {31'd0, carry8}, 32'd0);
        chk("t1.ovf", {31'd0, ovf8}, 32'd1);
        chk("t1.lat", lat, 8);

        // 2: FF + 01, busy exactly WIDTH cycles
        run_op(1'b0, 13'hFF, 13'h01, 1'b0, lat, bcyc);
        chk("t2.sum", {24'd0, sum8}, 32'h00);
        chk("t2.carry", {31'd0, carry8}, 32'd1);
        chk("t2.ovf", {31'd0, ovf8}, 32'd0);
        chk("t2.busy", bcyc, 8);

        // 3: subtraction with borrow, then signed overflow
        run_op(1'b0, 13'h10, 13'h20, 1'b1, lat, bcyc);
        chk("t3a.sum", {24'd0, sum8}, 32'hF0);
        chk("t3a.carry", {31'd0, carry8}, 32'd0);
        chk("t3a.ovf", {31'd0, ovf8}, 32'd0);
        run_op(1'b0, 13'h80, 13'h01, 1'b1, lat, bcyc);
        chk("t3b.sum", {24'd0, sum8}, 32'h7F);
        chk("t3b.carry", {31'd0, carry8}, 32'd1);
        chk("t3b.ovf", {31'd0, ovf8}, 32'd1);

        // 4: start held and operands churned during RUN; restart from DONE
        @(negedge clk);
        x8 = 8'h5A; y8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            x8 = ~x8; y8 = y8 + 8'h11; sub8 = ~sub8;
        end
        @(negedge clk);
        chk("t4a.done", {31'd0, done8}, 32'd1);
        chk("t4a.sum", {24'd0, sum8}, 32'h96);
        chk("t4a.flags", {30'd0, carry8, ovf8}, 32'h1);
        x8 = 8'h33; y8 = 8'h44; sub8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        chk("t4b.busy", {31'd0, busy8}, 32'd1);
        chk("t4b.hold", {24'd0, sum8}, 32'h96);
        wait_done(1'b0, lat, bcyc);
        chk("t4b.sum", {24'd0, sum8}, 32'h77);
        chk("t4b.flags", {30'd0, carry8, ovf8}, 32'h0);
        chk("t4b.lat", lat, 8);

        // 5: asynchronous reset in the middle of RUN
        @(negedge clk);
        x8 = 8'h12; y8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5.sum", {24'd0, sum8}, 32'h0);
        chk("t5.flags", {28'd0, carry8, ovf8, busy8, done8}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | done8 | busy8;
        end
        chk("t5.nodone", {31'd0, seen}, 32'd0);
        run_op(1'b0, 13'h80, 13'h01, 1'b1, lat, bcyc);
        chk("t5.sum", {24'd0, sum8}, 32'h7F);
        chk("t5.flags", {30'd0, carry8, ovf8}, 32'h3);

        // WIDTH=13 directed: 1FFF + 1 wraps with carry; 0FFF + 1 overflows
        run_op(1'b1, 13'h1FFF, 13'h0001, 1'b0, lat, bcyc);
        chk("w13a.sum", {19'd0, sum13}, 32'h0);
        chk("w13a.flags", {30'd0, carry13, ovf13}, 32'h2);
        chk("w13a.busy", bcyc, 13);
        run_op(1'b1, 13'h0FFF, 13'h0001, 1'b0, lat, bcyc);
        chk("w13b.sum", {19'd0, sum13}, 32'h1000);
        chk("w13b.flags", {30'd0, carry13, ovf13}, 32'h1);

        // Randomised sweep on both widths
        for (int n = 0; n < 100; n++) begin
            rx = $urandom; ry = $urandom; rs = 1'($urandom_range(0, 1));
            run_op(1'b0, rx[12:0], ry[12:0], rs, lat, bcyc);
            check_result(1'b0, "rnd8", model(8, rx, ry, rs), lat);
            rx = $urandom; ry = $urandom; rs = 1'($urandom_range(0, 1));
            run_op(1'b1, rx[12:0], ry[12:0], rs, lat, bcyc);
            check_result(1'b1, "rnd13", model(13, rx, ry, rs), lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
